// File: rtl/modulo_serializar_pkg.sv
// Shared types for the matrix serializer.
// Holds the FSM encoding and the default element width.
package modulo_serializar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int ELEM_W = 8;

endpackage

// File: rtl/modulo_serializar_indice.sv
// contador_indice: 2-D (row,col) walker over an N x N matrix.
// Ports: clr -> (0,0), adv steps in row/col-major order, last at (N-1,N-1).
module contador_indice
  import modulo_serializar_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          col_major,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic [IW-1:0] row_d;
  logic [IW-1:0] col_d;

  assign last = (row == MAX) && (col == MAX);

  always_comb begin
    row_d = row;
    col_d = col;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (!col_major) begin
        if (col == MAX) begin
          col_d = '0;
          row_d = (row == MAX) ? '0 : row + 1'b1;
        end else begin
          col_d = col + 1'b1;
        end
      end else begin
        if (row == MAX) begin
          row_d = '0;
          col_d = (col == MAX) ? '0 : col + 1'b1;
        end else begin
          row_d = row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_d;
      col <= col_d;
    end
  end

endmodule

// File: rtl/modulo_serializar.sv
// Captures an N x N matrix and streams it element by element.
// Ports: matrix_in/in_valid/in_ready/col_major in; out_* stream out; busy.
module modulo_serializar
  import modulo_serializar_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int W  = ELEM_W,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*N*W-1:0] matrix_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             col_major,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_row,
  output logic [IW-1:0]    out_col,
  output logic             out_last,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [N*N*W-1:0] buf_q;
  logic             cm_q;
  logic             last_idx;
  logic             acc;
  logic             load;

  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  assign out_last  = out_valid && last_idx;
  // Accepting the final element frees the buffer that same cycle,
  // so a waiting matrix loads back-to-back with no idle bubble.
  assign in_ready  = (state_q == IDLE) || (out_ready && out_last);
  assign acc       = out_valid && out_ready;
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = STREAM;
    end else if (acc && out_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      cm_q  <= 1'b0;
    end else if (load) begin
      buf_q <= matrix_in;
      cm_q  <= col_major;
    end
  end

  contador_indice #(
    .N(N)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .adv      (acc),
    .col_major(cm_q),
    .row      (out_row),
    .col      (out_col),
    .last     (last_idx)
  );

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N * N; k++) begin
      if (k == int'(out_row) * N + int'(out_col)) begin
        out_data = buf_q[k*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_modulo_serializar.sv
// Scoreboard bench for modulo_serializar (N=3, W=8).
// Stimulus pushes expected elements; a negedge monitor pops and compares.
module tb_modulo_serializar;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] r;
    logic [1:0] c;
    logic       l;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [71:0] matrix_in;
  logic        in_valid;
  logic        in_ready;
  logic        col_major;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        busy;

  int   total;
  int   bad;
  int   hs;
  exp_t q[$];
  logic [71:0] m1;
  logic [71:0] m2;
  exp_t held;
  logic stalled;
  logic pend;

  modulo_serializar #(.N(3), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .matrix_in(matrix_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .col_major(col_major),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_mat(input logic [71:0] m, input logic cm);
    exp_t e;
    int r, c;
    for (int k = 0; k < 9; k++) begin
      r = cm ? k % 3 : k / 3;
      c = cm ? k / 3 : k % 3;
      e.d = m[(r*3+c)*8 +: 8];
      e.r = 2'(r);
      e.c = 2'(c);
      e.l = (k == 8);
      q.push_back(e);
    end
  endtask

  // Returns right after the capturing edge (+1).
  task automatic load(input logic [71:0] m, input logic cm);
    int n;
    @(posedge clk); #1;
    matrix_in = m;
    col_major = cm;
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    push_mat(m, cm);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL timeout busy=%0b left=%0d exp=idle", busy, q.size());
    end
  endtask

  // Monitor: handshakes checked in order, stalls checked for stability.
  always @(negedge clk) begin
    exp_t g;
    exp_t e;
    if (!rst) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      g = '{d: out_data, r: out_row, c: out_col, l: out_last};
      if (stalled) chk("hold", 32'(g), 32'(held));
      if (out_ready) begin
        hs++;
        if (q.size() == 0) begin
          chk("extra_elem", 32'(g), 32'h1fff);
        end else begin
          e = q.pop_front();
          chk("elem", 32'(g), 32'(e));
        end
        stalled = 1'b0;
      end else begin
        held    = g;
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    total = 0; bad = 0; hs = 0; stalled = 1'b0;
    for (int k = 0; k < 9; k++) begin
      m1[k*8 +: 8] = 8'(8'h11 * (k + 1));
      m2[k*8 +: 8] = 8'(8'hA1 + k);
    end
    rst = 1'b0; matrix_in = '0; in_valid = 1'b0;
    col_major = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    // row-major, continuous sink, latency 1 and no gaps
    load(m1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("rm_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("rm_end", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // column-major
    load(m1, 1'b1);
    wait_idle();

    // backpressure 1,0,0,...
    begin
      int h0;
      h0 = hs;
      load(m1, 1'b0);
      for (int c = 0; c < 60; c++) begin
        out_ready = (c % 3 == 0);
        @(negedge clk);
        if (!busy) break;
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      chk("bp_hs", 32'(hs - h0), 32'd9);
      wait_idle();
    end

    // back-to-back load, in_valid raised mid-stream
    load(m1, 1'b0);
    pend = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      pend = in_valid && in_ready;
      @(posedge clk); #1;
      if (pend) begin
        push_mat(m2, 1'b0);
        in_valid = 1'b0;
      end
      if (c == 3) begin
        matrix_in = m2;
        in_valid  = 1'b1;
      end
    end
    @(negedge clk);
    chk("b2b_end", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // async reset after the 4th element
    load(m1, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_data", {24'd0, out_data}, 32'd0);
    q.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    load(m1, 1'b1);
    wait_idle();

    chk("hs_total", 32'(hs), 32'd58);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
